key_digit_display: RTL and testbench

//  Downstream consumer of the keypad scan FSM. Takes each newly decoded key
//  (hex 0-F) and shifts it into a two-digit history: newest on the right, previous on the left.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/seven_seg_decoder.sv | 12 +
 rtl/key_digit_display.sv | 148 ++++++++++++++
 tb/tb_key_digit_display.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and 7-seg patterns for the keypad display path.
// Exports hex_t, mux_state_t, SEG_BLANK and SEG_LUT (active-low {g,f,e,d,c,b,a}).
package keypad_pkg;

    typedef logic [3:0] hex_t;

    typedef enum logic [1:0] {
        SHOW_R,
        GAP_R,
        SHOW_L,
        GAP_L
    } mux_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex to active-low 7-segment decoder.
// Ports: hex (4-bit value in), seg (7-bit {g,f,e,d,c,b,a}, active-low out).
module seven_seg_decoder
    import keypad_pkg::*;
(
    input  hex_t       hex,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[hex];

endmodule

// File: rtl/key_digit_display.sv
// Two-digit key history shown on a multiplexed active-low 7-seg display.
// Ports: clk, reset (sync, high), key_valid, key_code[3:0] in;
//        seg[6:0], an[1:0], digit_new[3:0], digit_old[3:0] out.
// Optional macro BLANK_LEADING_EN: digits never captured since reset stay dark.
module key_digit_display
    import keypad_pkg::*;
#(
    parameter int SHOW_CYCLES = 24000,
    parameter int GAP_CYCLES  = 240,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  =
        CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    logic kv_q;
    logic cap;

    assign cap = key_valid & ~kv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            kv_q      <= 1'b0;
            digit_new <= '0;
            digit_old <= '0;
        end else begin
            kv_q <= key_valid;
            if (cap) begin
                digit_old <= digit_new;
                digit_new <= key_code;
            end
        end
    end

`ifdef BLANK_LEADING_EN
    logic [1:0] valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 2'b00;
        end else if (cap) begin
            valid <= {valid[0], 1'b1};
        end
    end
`endif

    mux_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SHOW_R;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        unique case (state)
            SHOW_R: if (cnt == SHOW_LAST) begin
                state_d = HAS_GAP ? GAP_R : SHOW_L;
                cnt_d   = '0;
            end
            GAP_R: if (cnt == GAP_LAST) begin
                state_d = SHOW_L;
                cnt_d   = '0;
            end
            SHOW_L: if (cnt == SHOW_LAST) begin
                state_d = HAS_GAP ? GAP_L : SHOW_R;
                cnt_d   = '0;
            end
            GAP_L: if (cnt == GAP_LAST) begin
                state_d = SHOW_R;
                cnt_d   = '0;
            end
            default: begin
                state_d = SHOW_R;
                cnt_d   = '0;
            end
        endcase
    end

    hex_t       shown;
    logic [6:0] shown_seg;
    logic       lit;

    assign shown = (state == SHOW_L) ? digit_old : digit_new;

`ifdef BLANK_LEADING_EN
    assign lit = (state == SHOW_L) ? valid[1] : valid[0];
`else
    assign lit = 1'b1;
`endif

    seven_seg_decoder u_dec (
        .hex (shown),
        .seg (shown_seg)
    );

    logic [6:0] seg_d;
    logic [1:0] an_d;

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = 2'b11;
        unique case (state)
            SHOW_R: begin
                an_d  = 2'b10;
                seg_d = lit ? shown_seg : SEG_BLANK;
            end
            SHOW_L: begin
                an_d  = 2'b01;
                seg_d = lit ? shown_seg : SEG_BLANK;
            end
            default: begin
                an_d  = 2'b11;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    // Registered so the shared bus and anodes switch on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= 2'b11;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_key_digit_display.sv
// Self-checking bench for key_digit_display (SHOW=8, GAP=2 and GAP=0 builds).
// Directed scenarios followed by random key/reset traffic against a timing model.
module tb_key_digit_display;

    localparam int S  = 8;
    localparam int G  = 2;
    localparam int P1 = 2 * (S + G);
    localparam int P2 = 2 * S;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [6:0] seg, seg2;
    logic [1:0] an, an2;
    logic [3:0] digit_new, digit_old, dn2, do2;

    key_digit_display #(
        .SHOW_CYCLES (S),
        .GAP_CYCLES  (G),
        .CNT_W       (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .seg       (seg),
        .an        (an),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    key_digit_display #(
        .SHOW_CYCLES (S),
        .GAP_CYCLES  (0),
        .CNT_W       (16)
    ) dut_nogap (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .seg       (seg2),
        .an        (an2),
        .digit_new (dn2),
        .digit_old (do2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         n = 0;
    logic [3:0] m_new = 0;
    logic [3:0] m_old = 0;
    bit         m_kv = 0;
    bit [1:0]   m_vld = 0;

    function automatic logic [6:0] enc(input logic [3:0] h);
        case (h)
            4'h0: enc = 7'h40;  4'h1: enc = 7'h79;
            4'h2: enc = 7'h24;  4'h3: enc = 7'h30;
            4'h4: enc = 7'h19;  4'h5: enc = 7'h12;
            4'h6: enc = 7'h02;  4'h7: enc = 7'h78;
            4'h8: enc = 7'h00;  4'h9: enc = 7'h10;
            4'hA: enc = 7'h08;  4'hB: enc = 7'h03;
            4'hC: enc = 7'h46;  4'hD: enc = 7'h21;
            4'hE: enc = 7'h06;  default: enc = 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // side: 0 right slot, 1 left slot, 2 dark
    function automatic logic [6:0] slot_seg(input int side);
        logic [6:0] s;
        s = 7'h7F;
        if (side == 0) s = enc(m_new);
        if (side == 1) s = enc(m_old);
`ifdef BLANK_LEADING_EN
        if (side == 0 && !m_vld[0]) s = 7'h7F;
        if (side == 1 && !m_vld[1]) s = 7'h7F;
`endif
        return s;
    endfunction

    task automatic tick(input bit r, input bit kv, input logic [3:0] kc);
        logic [6:0] e_seg, e_seg2;
        logic [1:0] e_an, e_an2;
        int p1, p2, side1, side2;
        reset     = r;
        key_valid = kv;
        key_code  = kc;
        @(posedge clk);
        #1;
        if (r) begin
            e_seg = 7'h7F; e_an = 2'b11;
            e_seg2 = 7'h7F; e_an2 = 2'b11;
            n = 0; m_new = 0; m_old = 0; m_kv = 0; m_vld = 0;
        end else begin
            p1 = n % P1;
            p2 = n % P2;
            side1 = (p1 < S) ? 0 : (p1 < S + G) ? 2 : (p1 < 2 * S + G) ? 1 : 2;
            side2 = (p2 < S) ? 0 : 1;
            e_an  = (side1 == 0) ? 2'b10 : (side1 == 1) ? 2'b01 : 2'b11;
            e_an2 = (side2 == 0) ? 2'b10 : 2'b01;
            e_seg  = slot_seg(side1);
            e_seg2 = slot_seg(side2);
            if (kv && !m_kv) begin
                m_old = m_new;
                m_new = kc;
                m_vld = {m_vld[0], 1'b1};
            end
            m_kv = kv;
            n++;
        end
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("digit_new", digit_new, m_new);
        check("digit_old", digit_old, m_old);
        check("an_nogap", an2, e_an2);
        check("seg_nogap", seg2, e_seg2);
        check("digit_new_nogap", dn2, m_new);
    endtask

    initial begin
        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;

        repeat (3) tick(1, 0, 0);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 2'b11);
        tick(0, 0, 0);
        check("rst_digits", {digit_old, digit_new}, 8'h00);

        repeat (50) tick(0, 1, 4'h5);
        repeat (3) tick(0, 0, 4'h0);
        repeat (10) tick(0, 1, 4'hA);
        tick(0, 0, 4'h0);
        check("s2_new", digit_new, 4'hA);
        check("s2_old", digit_old, 4'h5);

        repeat (40) tick(0, 0, 0);

        while ((n % P1) != S - 1) tick(0, 0, 0);
        repeat (3) tick(0, 1, 4'h3);
        while ((n % P1) != 1) tick(0, 0, 0);
        check("s4_seg", seg, 7'h30);
        check("s4_an", an, 2'b10);

        while ((n % P1) != S + G + 3) tick(0, 0, 0);
        tick(0, 1, 4'h7);
        tick(1, 1, 4'h7);
        check("s5_dark_an", an, 2'b11);
        check("s5_dark_seg", seg, 7'h7F);
        tick(0, 1, 4'h7);
        check("s5_new", digit_new, 4'h7);
        check("s5_old", digit_old, 4'h0);
        repeat (4) tick(0, 1, 4'h7);
        tick(0, 0, 0);

        repeat (150) begin
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(1, 2))
                    tick(1, $urandom_range(0, 1), 4'($urandom));
            end else begin
                repeat ($urandom_range(1, 25))
                    tick(0, 1, 4'($urandom));
                repeat ($urandom_range(1, 8))
                    tick(0, 0, 4'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
